// File: rtl/normalize_pipe_pkg.sv
// Shared helpers for the pipelined leading-zero normalizer.
package normalize_pipe_pkg;

  // Smallest r such that 2**r >= n.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Number of register stages needed to cover logw shift levels.
  function automatic int num_stages(input int logw, input int lps);
    return (logw + lps - 32'sd1) / lps;
  endfunction

endpackage

// File: rtl/normalize_pipe_if.sv
// Input/output handshake bundle of the normalizer.
interface normalize_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  import normalize_pipe_pkg::*;

  localparam int LOGW = ceil_log2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LOGW-1:0]  out_dist;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  // Producer/consumer side (upstream stage and rounding stage).
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_dist, out_zero, out_tag
  );

  // The normalizer itself.
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_dist, out_zero, out_tag
  );
endinterface

// File: rtl/normalize_pipe_stage.sv
// One pipeline stage: a few shift levels followed by the stage register set.
module normalize_pipe_stage
  import normalize_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int FIRST_LEVEL = 4,
  parameter int NUM_LEVELS  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_adv,
  input  logic                        i_valid,
  input  logic [WIDTH-1:0]            i_data,
  input  logic [ceil_log2(WIDTH)-1:0] i_dist,
  input  logic                        i_zero,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_valid,
  output logic [WIDTH-1:0]            o_data,
  output logic [ceil_log2(WIDTH)-1:0] o_dist,
  output logic                        o_zero,
  output logic [TAG_W-1:0]            o_tag
);
  localparam int LOGW = ceil_log2(WIDTH);

  logic [LOGW-1:0]  w_dist;
  logic [WIDTH-1:0] w_data;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [LOGW-1:0]  r_dist;
  logic             r_zero;
  logic [TAG_W-1:0] r_tag;

  // Level chain, MSB level first: shift by 2^k when the top 2^k bits are clear.
  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
    localparam int SH = 1 << (FIRST_LEVEL - i);
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_out;
    logic             w_hit;
    if (i == 0) begin : g_first
      assign w_in = i_data;
    end else begin : g_next
      assign w_in = g_lvl[i-1].w_out;
    end
    assign w_hit = (w_in[WIDTH-1 -: SH] == {SH{1'b0}});
    assign w_out = w_hit ? (w_in << SH) : w_in;
  end

  assign w_data = g_lvl[NUM_LEVELS-1].w_out;

  // Distance bits owned by this stage come from its levels; the rest pass through
  // (incoming bits at this stage's levels are still zero, so OR-ing is exact).
  for (genvar b = 0; b < LOGW; b++) begin : g_dist
    if ((b <= FIRST_LEVEL) && (b > FIRST_LEVEL - NUM_LEVELS)) begin : g_own
      assign w_dist[b] = i_dist[b] | g_lvl[FIRST_LEVEL-b].w_hit;
    end else begin : g_pass
      assign w_dist[b] = i_dist[b];
    end
  end

  // Stage registers: reset clears everything, flush drops the valid bit, advance loads.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
      r_dist  <= {LOGW{1'b0}};
      r_zero  <= 1'b0;
      r_tag   <= {TAG_W{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_data;
      r_dist  <= w_dist;
      r_zero  <= i_zero;
      r_tag   <= i_tag;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dist  = r_dist;
  assign o_zero  = r_zero;
  assign o_tag   = r_tag;
endmodule

// File: rtl/normalize_pipe.sv
// Pipelined leading-zero normalizer: stage chain, ready chain and flush fan-out.
module normalize_pipe
  import normalize_pipe_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  normalize_pipe_if.slave  bus
);
  localparam int LOGW   = ceil_log2(WIDTH);
  localparam int STAGES = num_stages(LOGW, LEVELS_PER_STAGE);

  // Index 0 is the pipe input, index s+1 is the register output of stage s.
  logic             w_valid [0:STAGES];
  logic [WIDTH-1:0] w_data  [0:STAGES];
  logic [LOGW-1:0]  w_dist  [0:STAGES];
  logic             w_zero  [0:STAGES];
  logic [TAG_W-1:0] w_tag   [0:STAGES];
  logic [STAGES-1:0] w_adv;

  assign w_valid[0] = bus.in_valid;
  assign w_data[0]  = bus.in_data;
  assign w_dist[0]  = {LOGW{1'b0}};
  assign w_zero[0]  = (bus.in_data == {WIDTH{1'b0}});
  assign w_tag[0]   = bus.in_tag;

  // Ready chain flattened: a stage advances if it or any later stage is empty,
  // or the consumer takes the result.
  always_comb begin
    w_adv = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      logic v_acc;
      v_acc = bus.out_ready;
      for (int j = i + 1; j <= STAGES; j++) begin
        v_acc = v_acc | ~w_valid[j];
      end
      w_adv[i] = v_acc;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = LOGW - 1 - s * LEVELS_PER_STAGE;
    localparam int NUM   = (FIRST + 1 < LEVELS_PER_STAGE) ? (FIRST + 1) : LEVELS_PER_STAGE;
    normalize_pipe_stage #(
      .WIDTH       (WIDTH),
      .TAG_W       (TAG_W),
      .FIRST_LEVEL (FIRST),
      .NUM_LEVELS  (NUM)
    ) u_stage (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_flush   (flush),
      .i_adv     (w_adv[s]),
      .i_valid   (w_valid[s]),
      .i_data    (w_data[s]),
      .i_dist    (w_dist[s]),
      .i_zero    (w_zero[s]),
      .i_tag     (w_tag[s]),
      .o_valid   (w_valid[s+1]),
      .o_data    (w_data[s+1]),
      .o_dist    (w_dist[s+1]),
      .o_zero    (w_zero[s+1]),
      .o_tag     (w_tag[s+1])
    );
  end

  assign bus.in_ready  = w_adv[0] & ~flush;
  assign bus.out_valid = w_valid[STAGES];
  assign bus.out_data  = w_data[STAGES];
  assign bus.out_dist  = w_dist[STAGES];
  assign bus.out_zero  = w_zero[STAGES];
  assign bus.out_tag   = w_tag[STAGES];
endmodule
